instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the datapath immediate sign-extension stage: takes decoded fields plus a 64-bit signed immediate and packs a 32-bit RV64I instruction word.
- Used by the instruction-memory preloader and the test harness to build programs in hardware.
- Stream block: valid/ready in, valid/ready out, one-entry output register.
- Emits a running word address for instruction-memory writes.

Parameters:
- BASE_ADDR, 64'h0, byte address assigned to the first emitted instruction.
- DEPTH, 256, number of instruction words before the address wraps to BASE_ADDR. Must be a power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of the pipeline register and the address counter.
- in_valid  in  1  input fields valid.
- in_ready  out  1  block can accept this cycle.
- in_fmt  in  3  fmt_t: I, S, SB, U, UJ, R.
- in_opcode  in  7  opcode[6:0].
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R only).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  64  signed immediate, byte offset.
- out_valid  out  1  encoded word held.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  64  byte address of out_instr.
- out_err  out  1  immediate out of range or misaligned for its format.
- err_count  out  8  saturating count of emitted words with out_err=1.

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_count=0.
- States:
  - EMPTY: out_valid=0, in_ready=1.
  - FULL: out_valid=1, in_ready=out_ready.
- Transitions:
  - EMPTY→FULL on in_valid.
  - FULL stays FULL on simultaneous in_valid and out_ready (new word loaded).
  - FULL→EMPTY on out_ready with !in_valid.
- Latency 1 cycle from input handshake to out_valid. Throughput 1 word/cycle.
- out_instr, out_err and out_addr are stable while out_valid && !out_ready.
- Address counter:
  - Advances by 4 on each output handshake.
  - After BASE_ADDR + 4*(DEPTH-1) it wraps to BASE_ADDR.
  - Each word loaded takes the counter's current value.
- Packing (bit ranges high→low):
  - R: funct7, rs2, rs1, funct3, rd, opcode.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - SB: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - UJ: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - Undefined fmt codes: out_instr=0, out_err=1.
- err_count increments on each output handshake with out_err=1 and holds at 8'hFF.
- flush:
  - Clears out_valid and out_addr (to BASE_ADDR) next edge.
  - Does not clear err_count.
  - Input presented in the flush cycle is dropped; in_ready stays 1 during flush.
- rst and flush together: rst wins. Reset mid-stream discards the held word.

Optional Feature:
- Macro RANGE_CHECK_EN.
- Defined: out_err=1 when any of the following holds:
  - I/S immediate outside [-2048, 2047].
  - SB immediate outside [-4096, 4094], or imm[0]=1.
  - UJ immediate outside [-2^20, 2^20-2], or imm[0]=1.
  - U: imm[11:0]≠0, or imm[63:31] not all equal.
- Not defined: out_err is set only for undefined fmt; out-of-range fields are silently truncated.

Decomposition:
- Package instr_pkg holds:
  - fmt_t enum: FMT_I=0, FMT_S=1, FMT_SB=2, FMT_U=3, FMT_UJ=4, FMT_R=5.
  - Opcode constants: OP_IMM=7'h13, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F, OP_JALR=7'h67.
  - State enum.
- One combinational sub-module, imm_pack: fmt plus fields in, instr and err out.
- The stateful wrapper instr_encoder holds the register, FSM, address counter and error counter.

Test Plan:
- addi x1,x0,-1: FMT_I, op 13, f3 0, rd 1, rs1 0, imm -1 → out_instr=FFF00093, out_addr=0, next cycle out_valid=1.
- ld x5,8(x2) then sd x5,16(x2): FMT_I op 03 f3 3, then FMT_S op 23 f3 3 → 00813283 at addr 0, then 00513823 at addr 4.
- beq x1,x2,-8 (FMT_SB) → FE208CE3. lui x3 with imm 0x12345000 → 123451B7.
- FMT_I imm=2048, op 13, rd 1:
  - With RANGE_CHECK_EN → out_err=1, err_count=1.
  - Without it → out_err=0, out_instr=80000093.
- Backpressure: hold out_ready=0 for 3 cycles after load → in_ready=0 and out_instr stable. Then stream DEPTH+1 words → last word address wraps to BASE_ADDR.
- Assert flush with out_valid=1 → next cycle out_valid=0, out_addr=BASE_ADDR, err_count unchanged. Assert rst with flush → full reset values.

Source files
------------

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and opcode constants for the RV64I instruction encoder
// Contents: fmt_t (instruction format codes), base opcode constants, state_t (output register state).
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_SB = 3'd2,
    FMT_U  = 3'd3,
    FMT_UJ = 3'd4,
    FMT_R  = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational packing of decoded fields and immediate into a 32-bit RV64I word
// Ports: fmt_i/opcode_i/funct3_i/funct7_i/rd_i/rs1_i/rs2_i/imm_i fields in; instr_o packed word, err_o bad format/immediate.
// Build option: RANGE_CHECK_EN adds immediate range/alignment checks to err_o.
module imm_pack
  import instr_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [63:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

`ifdef RANGE_CHECK_EN
  // A value fits an N-bit signed field when every bit from N-1 upward is a copy of the sign.
  logic fits_12, fits_13, fits_21, fits_32;
  assign fits_12 = (&imm_i[63:11]) | ~(|imm_i[63:11]);
  assign fits_13 = (&imm_i[63:12]) | ~(|imm_i[63:12]);
  assign fits_21 = (&imm_i[63:20]) | ~(|imm_i[63:20]);
  assign fits_32 = (&imm_i[63:31]) | ~(|imm_i[63:31]);
`else
  logic unused_imm;
  assign unused_imm = ^imm_i[63:32];
`endif

  always_comb begin
    instr_o = 32'h0;
    err_o   = 1'b0;
    case (fmt_i)
      FMT_R:  instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I:  instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S:  instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_SB: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                         imm_i[4:1], imm_i[11], opcode_i};
      FMT_U:  instr_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_UJ: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: begin
        instr_o = 32'h0;
        err_o   = 1'b1;
      end
    endcase
`ifdef RANGE_CHECK_EN
    case (fmt_i)
      FMT_I, FMT_S: if (!fits_12) err_o = 1'b1;
      // SB upper bound 4094 is implied by fits_13 plus the even check.
      FMT_SB:       if (!fits_13 || imm_i[0]) err_o = 1'b1;
      FMT_UJ:       if (!fits_21 || imm_i[0]) err_o = 1'b1;
      FMT_U:        if (!fits_32 || (imm_i[11:0] != 12'h0)) err_o = 1'b1;
      default:      ;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - stream wrapper: one-entry output register, word address counter, error counter
// Ports: clk, rst (sync, active-high), flush; in_* handshake + fields; out_valid/out_ready handshake,
//        out_instr, out_addr, out_err; err_count saturating errored-word count.
// Build option: RANGE_CHECK_EN (passed to imm_pack).
module instr_encoder
  import instr_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state_q;
  logic [AW-1:0] cnt_q, cnt_d, cnt_nxt, load_idx;
  logic [31:0]   instr_q;
  logic [63:0]   addr_q;
  logic          err_q;
  logic [7:0]    errcnt_q, errcnt_d;
  logic [31:0]   pack_instr;
  logic          pack_err;
  logic          hs;

  imm_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign out_err   = err_q;
  assign err_count = errcnt_q;
  assign in_ready  = flush | ~out_valid | out_ready;
  assign hs        = out_valid & out_ready;

  // cnt_q indexes the word that will be emitted next; a word loaded in the
  // same cycle its predecessor leaves takes the already-advanced index.
  assign cnt_nxt  = (cnt_q == AW'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
  assign cnt_d    = hs ? cnt_nxt : cnt_q;
  assign load_idx = cnt_d;
  assign errcnt_d = (hs && err_q && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      instr_q  <= 32'h0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      errcnt_q <= 8'h0;
      cnt_q    <= '0;
    end else begin
      errcnt_q <= errcnt_d;
      if (flush) begin
        state_q <= ST_EMPTY;
        addr_q  <= BASE_ADDR;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (in_valid && in_ready) begin
          state_q <= ST_FULL;
          instr_q <= pack_instr;
          err_q   <= pack_err;
          addr_q  <= BASE_ADDR + {{(62-AW){1'b0}}, load_idx, 2'b00};
        end else if (hs) begin
          state_q <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a transaction-level model
module tb_instr_encoder;

  localparam logic [63:0] BASE  = 64'h0;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm, out_addr;
  logic [31:0] out_instr;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding straight from the format tables, using shifts and masks on integers.
  function automatic logic [32:0] ref_enc(input longint unsigned fmt, op, f3, f7, rd, rs1, rs2,
                                          input longint imm);
    longint unsigned u = imm;
    longint unsigned w = 0;
    bit e = 0;
    case (fmt)
      0: begin
        w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        if (imm < -2048 || imm > 2047) e = RC;
      end
      1: begin
        w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 'h1F) << 7) | op;
        if (imm < -2048 || imm > 2047) e = RC;
      end
      2: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
            (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | op;
        if (imm < -4096 || imm > 4094 || (u & 1) != 0) e = RC;
      end
      3: begin
        w = (u & 'hFFFFF000) | (rd << 7) | op;
        if ((u & 'hFFF) != 0 || imm < -64'sd2147483648 || imm > 64'sd2147483647) e = RC;
      end
      4: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 'hFF) << 12) | (rd << 7) | op;
        if (imm < -(64'sd1 << 20) || imm > (64'sd1 << 20) - 2 || (u & 1) != 0) e = RC;
      end
      5: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: begin w = 0; e = 1; end
    endcase
    return {e, w[31:0]};
  endfunction

  // Transaction-level model: the held word, its address and the running emitted-word count.
  bit          m_init = 0;
  bit          m_valid, m_err;
  logic [31:0] m_instr;
  logic [63:0] m_addr;
  longint      m_n;
  int          m_errcnt;

  always @(posedge clk) begin : model
    bit hs;
    logic [32:0] enc;
    if (rst) begin
      m_init = 1; m_valid = 0; m_err = 0; m_instr = 0; m_addr = BASE; m_n = 0; m_errcnt = 0;
    end else if (m_init) begin
      hs = m_valid && out_ready;
      if (hs) begin
        m_n++;
        if (m_err && m_errcnt < 255) m_errcnt++;
      end
      if (flush) begin
        m_valid = 0; m_addr = BASE; m_n = 0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        enc = ref_enc(in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
        m_valid = 1; m_instr = enc[31:0]; m_err = enc[32];
        m_addr = BASE + 64'((m_n % DEPTH) * 4);
      end else if (hs) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready",  64'(in_ready),  64'(flush || !m_valid || out_ready));
      chk("out_instr", 64'(out_instr), 64'(m_instr));
      chk("out_addr",  out_addr,       m_addr);
      chk("out_err",   64'(out_err),   64'(m_err));
      chk("err_count", 64'(err_count), 64'(m_errcnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic put(input int fmt, op, f3, rd, rs1, rs2, input longint imm);
    in_valid = 1; in_fmt = 3'(fmt); in_opcode = 7'(op); in_funct3 = 3'(f3); in_funct7 = 0;
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
  endtask

  longint bounds [14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                          -1048576, 1048574, 1048576, 64'sh7FFFF000, -64'sh80000000};

  initial begin
    rst = 1; flush = 0; out_ready = 0;
    put(0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    tick(); tick();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_instr", 64'(out_instr), 0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_errcnt", 64'(err_count), 0);
    rst = 0;

    put(0, 'h13, 0, 1, 0, 0, -1);
    tick();
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_instr", 64'(out_instr), 64'h FFF00093);
    chk("addi_addr", out_addr, BASE);
    put(0, 'h03, 3, 5, 2, 0, 8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_instr", 64'(out_instr), 64'h FFF00093);
    end

    flush = 1;
    #1 chk("flush_in_ready", 64'(in_ready), 1);
    tick();
    flush = 0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_addr", out_addr, BASE);
    chk("flush_errcnt", 64'(err_count), 0);

    out_ready = 1;
    put(0, 'h03, 3, 5, 2, 0, 8);  tick();
    chk("ld_instr", 64'(out_instr), 64'h 00813283);
    chk("ld_addr", out_addr, BASE);
    put(1, 'h23, 3, 0, 2, 5, 16); tick();
    chk("sd_instr", 64'(out_instr), 64'h 00513823);
    chk("sd_addr", out_addr, BASE + 4);
    put(2, 'h63, 0, 0, 1, 2, -8); tick();
    chk("beq_instr", 64'(out_instr), 64'h FE208CE3);
    put(3, 'h37, 0, 3, 0, 0, 64'h12345000); tick();
    chk("lui_instr", 64'(out_instr), 64'h 123451B7);
    chk("lui_addr", out_addr, BASE + 12);
    put(0, 'h13, 0, 1, 0, 0, 2048); tick();
    chk("imm2048_instr", 64'(out_instr), 64'h 80000093);
    chk("imm2048_err", 64'(out_err), 64'(RC));
    in_valid = 0; tick();
    chk("imm2048_errcnt", 64'(err_count), 64'(RC));

    flush = 1; tick(); flush = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      put(0, 'h13, 0, k % 32, 1, 0, k % 2000);
      tick();
      if (k == DEPTH - 1) chk("wrap_last", out_addr, BASE + 64'(4 * (DEPTH - 1)));
      if (k == DEPTH) chk("wrap_base", out_addr, BASE);
    end
    in_valid = 0; tick();

    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst       = ($urandom_range(0, 399) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_opcode = 7'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: in_imm = 64'(longint'($urandom_range(0, 10000)) - 5000);
        1: in_imm = {$urandom, $urandom};
        2: in_imm = 64'(bounds[$urandom_range(0, 13)]);
        default: in_imm = 64'(longint'(int'($urandom)) & ~longint'('hFFF));
      endcase
      tick();
    end

    rst = 1; flush = 1; in_valid = 1; out_ready = 1;
    tick();
    rst = 0; flush = 0; in_valid = 0;
    chk("rstflush_valid", 64'(out_valid), 0);
    chk("rstflush_instr", 64'(out_instr), 0);
    chk("rstflush_addr", out_addr, BASE);
    chk("rstflush_err", 64'(out_err), 0);
    chk("rstflush_errcnt", 64'(err_count), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
